// File: rtl/ltc2387_deser_if.sv
// ltc2387_deser_if: bundles the deserializer's lane inputs and result outputs.
//   bits_18, two_lane            frame mode (18-bit frame, DA+DB lanes)
//   clk_en                       CLK-pulse enable from the timing controller
//   da_r, da_f, db_r, db_f       lane bits captured on CLK rise / fall
//   data[17:0], data_valid       last good result and its update strobe
//   frame_err, err_cnt[7:0]      bad-frame strobe and saturating count
//   master drives the lanes (ADC side), slave is the deserializer.
interface ltc2387_deser_if;
   logic        bits_18, two_lane, clk_en, da_r, da_f, db_r, db_f;
   logic [17:0] data;
   logic        data_valid, frame_err;
   logic [7:0]  err_cnt;
   modport master (output bits_18, two_lane, clk_en, da_r, da_f, db_r, db_f,
                   input data, data_valid, frame_err, err_cnt);
   modport slave (input bits_18, two_lane, clk_en, da_r, da_f, db_r, db_f,
                  output data, data_valid, frame_err, err_cnt);
endinterface

// File: rtl/ltc2387_deser.sv
// ltc2387_deser: LTC2385/6/7 DDR receive deserializer, one result per clk_en window.
//   clk, rst_n   master clock, asynchronous active-low reset
//   io (slave)   lane inputs, frame mode, result/strobe/error outputs
//   RT_DELAY     0..7 cycles of clk_en delay to match the board round trip
//   LTC_DESER_SIGNEXT_EN  when defined, 16-bit results are sign-extended to 18 bits
module ltc2387_deser #(
   parameter int RT_DELAY = 2
) (
   input logic           clk,
   input logic           rst_n,
   ltc2387_deser_if.slave io
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      state_q, state_d;
   logic        en_d;
   logic        b18_q, b18_d, tl_q, tl_d, dv_q, dv_d, fe_q, fe_d;
   logic [4:0]  cnt_q, cnt_d, cnt, n, exp_cnt;
   logic [17:0] sh_q, sh_d, sh, data_q, data_d, res;
   logic [7:0]  err_q, err_d;
   logic [3:0]  lane;
   logic [1:0]  ext;
   logic        b18, tl;
   if (RT_DELAY == 0) begin : g_nodly
      assign en_d = io.clk_en;
   end else begin : g_dly
      logic [RT_DELAY-1:0] dl_q, dl_d;
      always_comb dl_d = RT_DELAY'({dl_q, io.clk_en});
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) dl_q <= '0;
         else dl_q <= dl_d;
      assign en_d = dl_q[RT_DELAY-1];
   end
   // Mode comes straight from the pins on the frame's first cycle, then from the latch.
   always_comb begin
      b18  = (state_q == IDLE) ? io.bits_18 : b18_q;
      tl   = (state_q == IDLE) ? io.two_lane : tl_q;
      lane = tl ? {io.da_r, io.db_r, io.da_f, io.db_f} : {io.da_r, io.da_f, 2'b00};
      n    = b18 ? 5'd18 : 5'd16;
      cnt  = (state_q == IDLE) ? 5'd0 : cnt_q;
      sh   = (state_q == IDLE) ? 18'd0 : sh_q;
      // Bits past the frame length are counted but not shifted in.
      for (int i = 0; i < 4; i++) begin
         if (i < 2 || tl) begin
            if (cnt < n) sh = {sh[16:0], lane[3-i]};
            cnt = (cnt == 5'd31) ? cnt : cnt + 5'd1;
         end
      end
   end
   always_comb begin
      exp_cnt = tl_q ? (b18_q ? 5'd20 : 5'd16) : (b18_q ? 5'd18 : 5'd16);
`ifdef LTC_DESER_SIGNEXT_EN
      ext = {2{sh_q[15]}};
`else
      ext = 2'b00;
`endif
      res     = b18_q ? sh_q : {ext, sh_q[15:0]};
      state_d = state_q;
      b18_d   = b18_q;
      tl_d    = tl_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      data_d  = data_q;
      err_d   = err_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: if (en_d) begin
            state_d = SHIFT;
            b18_d   = io.bits_18;
            tl_d    = io.two_lane;
            cnt_d   = cnt;
            sh_d    = sh;
         end
         SHIFT: if (en_d) begin
            cnt_d = cnt;
            sh_d  = sh;
         end else state_d = DONE;
         DONE: begin
            state_d = IDLE;
            if (cnt_q == exp_cnt) begin
               data_d = res;
               dv_d   = 1'b1;
            end else begin
               fe_d  = 1'b1;
               err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         b18_q   <= 1'b0;
         tl_q    <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         err_q   <= '0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         b18_q   <= b18_d;
         tl_q    <= tl_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         err_q   <= err_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
      end
   assign io.data       = data_q;
   assign io.data_valid = dv_q;
   assign io.frame_err  = fe_q;
   assign io.err_cnt    = err_q;
endmodule

// File: tb/tb_ltc2387_deser.sv
// tb_ltc2387_deser: table-driven frames plus reset and error-saturation sequences.
module tb_ltc2387_deser;
   localparam int RTD = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   ltc2387_deser_if io ();
   ltc2387_deser #(.RT_DELAY(RTD)) dut (.clk(clk), .rst_n(rst_n), .io(io));
   typedef struct {
      logic        b18;
      logic        tl;
      logic        flip;
      logic [17:0] word;
      int          w;
      logic        good;
      logic [17:0] exp_data;
      logic [7:0]  exp_err;
   } vec_t;
   vec_t v[10];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   function automatic logic bit_at(input logic [17:0] w, input int p);
      return (p < 0) ? 1'b1 : w[p];
   endfunction
   // Drives clk_en for cycle c and the lane bits for delayed window cycle j.
   task automatic drive(input logic en, input vec_t t, input int j);
      int nb;
      nb = t.b18 ? 18 : 16;
      io.clk_en = en;
      {io.da_r, io.da_f, io.db_r, io.db_f} = 4'b0000;
      if (j >= 0 && j < t.w) begin
         if (t.tl) begin
            io.da_r = bit_at(t.word, nb - 1 - 4 * j);
            io.db_r = bit_at(t.word, nb - 2 - 4 * j);
            io.da_f = bit_at(t.word, nb - 3 - 4 * j);
            io.db_f = bit_at(t.word, nb - 4 - 4 * j);
         end else begin
            io.da_r = bit_at(t.word, nb - 1 - 2 * j);
            io.da_f = bit_at(t.word, nb - 2 - 2 * j);
         end
      end
   endtask
   task automatic run_frame(input vec_t t, input string tag);
      int          ndv, nfe, lat;
      logic        hold_ok;
      logic [17:0] prev;
      ndv = 0; nfe = 0; lat = -1; hold_ok = 1'b1;
      io.bits_18 = t.b18;
      io.two_lane = t.tl;
      prev = io.data;
      for (int c = 0; c <= t.w + RTD + 6; c++) begin
         @(negedge clk);
         if (io.data_valid) begin ndv++; lat = c; end
         if (io.frame_err) begin nfe++; lat = c; end
         if (io.data !== prev && !io.data_valid) hold_ok = 1'b0;
         prev = io.data;
         if (t.flip && c == RTD + 2) begin
            io.bits_18 = ~t.b18;
            io.two_lane = ~t.tl;
         end
         drive(c < t.w, t, c - RTD);
      end
      chk({tag, " dv_pulses"}, ndv, t.good ? 1 : 0);
      chk({tag, " fe_pulses"}, nfe, t.good ? 0 : 1);
      chk({tag, " latency"}, lat, t.w + RTD + 2);
      chk({tag, " data"}, io.data, t.exp_data);
      chk({tag, " err_cnt"}, io.err_cnt, t.exp_err);
      chk({tag, " data_hold"}, hold_ok, 1);
   endtask
   initial begin
      vec_t        t;
      int          ndv, nfe;
      logic [17:0] se8001;
`ifdef LTC_DESER_SIGNEXT_EN
      se8001 = 18'h38001;
`else
      se8001 = 18'h08001;
`endif
      v[0] = '{1'b0, 1'b0, 1'b0, 18'h0A5C3, 8, 1'b1, 18'h0A5C3, 8'd0};
      v[1] = '{1'b1, 1'b1, 1'b0, 18'h2ABCD, 5, 1'b1, 18'h2ABCD, 8'd0};
      v[2] = '{1'b1, 1'b0, 1'b0, 18'h3FFFF, 8, 1'b0, 18'h2ABCD, 8'd1};
      v[3] = '{1'b0, 1'b0, 1'b0, 18'h08001, 8, 1'b1, se8001,    8'd1};
      v[4] = '{1'b0, 1'b1, 1'b0, 18'h01234, 4, 1'b1, 18'h01234, 8'd1};
      v[5] = '{1'b1, 1'b0, 1'b0, 18'h1E0F1, 9, 1'b1, 18'h1E0F1, 8'd1};
      v[6] = '{1'b0, 1'b1, 1'b0, 18'h0AAAA, 5, 1'b0, 18'h1E0F1, 8'd2};
      v[7] = '{1'b1, 1'b1, 1'b0, 18'h15555, 4, 1'b0, 18'h1E0F1, 8'd3};
      v[8] = '{1'b0, 1'b0, 1'b0, 18'h0FFFF, 9, 1'b0, 18'h1E0F1, 8'd4};
      v[9] = '{1'b0, 1'b0, 1'b1, 18'h07FFF, 8, 1'b1, 18'h07FFF, 8'd4};
      io.bits_18 = 1'b0; io.two_lane = 1'b0; io.clk_en = 1'b0;
      {io.da_r, io.da_f, io.db_r, io.db_f} = 4'b0000;
      repeat (2) @(negedge clk);
      chk("rst data", io.data, 0);
      chk("rst data_valid", io.data_valid, 0);
      chk("rst frame_err", io.frame_err, 0);
      chk("rst err_cnt", io.err_cnt, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 10; k++) run_frame(v[k], $sformatf("vec%0d", k));
      // Reset pulse inside a window: no strobe for that frame.
      t = '{1'b0, 1'b0, 1'b0, 18'h00F0F, 6, 1'b1, 18'h00F0F, 8'd0};
      io.bits_18 = 1'b0; io.two_lane = 1'b0;
      ndv = 0; nfe = 0;
      for (int c = 0; c <= t.w + RTD + 6; c++) begin
         @(negedge clk);
         if (io.data_valid) ndv++;
         if (io.frame_err) nfe++;
         if (c == 5) begin
            rst_n = 1'b0;
            #1;
            chk("midrst data", io.data, 0);
            chk("midrst data_valid", io.data_valid, 0);
            chk("midrst frame_err", io.frame_err, 0);
            chk("midrst err_cnt", io.err_cnt, 0);
         end
         if (c == 6) rst_n = 1'b1;
         drive(c < t.w, t, c - RTD);
      end
      chk("midrst dv_pulses", ndv, 0);
      chk("midrst fe_pulses", nfe, 0);
      t.w = 8;
      run_frame(t, "after_rst");
      // 300 two-bit frames, each a length error.
      io.bits_18 = 1'b0; io.two_lane = 1'b0;
      {io.da_r, io.da_f, io.db_r, io.db_f} = 4'b0000;
      ndv = 0; nfe = 0;
      for (int c = 0; c < 1210; c++) begin
         @(negedge clk);
         if (io.data_valid) ndv++;
         if (io.frame_err) nfe++;
         io.clk_en = (c < 1200) && (c % 4 == 0);
      end
      chk("sat fe_pulses", nfe, 300);
      chk("sat dv_pulses", ndv, 0);
      chk("sat err_cnt", io.err_cnt, 255);
      t = '{1'b0, 1'b0, 1'b0, 18'h0BEEF, 8, 1'b1, 18'h0BEEF, 8'd255};
      run_frame(t, "after_sat");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
